inst_fetch_bridge: RTL

Instruction-side responder for the fetch interface: accepts the instruction address and chip-enable issued by the PC stage and performs a multi-cycle read of the external base SRAM. It returns the 32-bit instruction to the IF/ID stage and raises a stall request to the control module while the access is in flight. Read-only. Arbitrates the shared base SRAM against the data-side load/store path.

---
 rtl/inst_fetch_bridge.sv | 112 +++++++++++
 1 files changed

// File: rtl/inst_fetch_bridge.sv
// Instruction-side fetch bridge: turns a PC-stage fetch into a multi-cycle base SRAM read,
// stalls the pipeline while the read is in flight and yields the SRAM to data-side requests.
module inst_fetch_bridge #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        data_req_i,
    input  logic [31:0] sram_data_i,
    output logic [19:0] sram_addr_o,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [3:0]  sram_be_n_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stallreq_o,
    output logic        busy_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [19:0] addr_q, addr_d;
    logic        en_n_q, en_n_d;
    logic [3:0]  be_n_q, be_n_d;
    logic [31:0] inst_q, inst_d;

    // Only word-address bits reach the SRAM; the rest of the PC is don't-care here.
    logic unused_pc;
    assign unused_pc = ^{pc_i[31:22], pc_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 20'd0;
            en_n_q  <= 1'b1;
            be_n_q  <= 4'hF;
            inst_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            en_n_q  <= en_n_d;
            be_n_q  <= be_n_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        en_n_d  = en_n_q;
        be_n_d  = be_n_q;
        inst_d  = inst_q;
        case (state_q)
            IDLE: begin
                // Data side has priority whenever it asks while we are idle.
                if (ce_i && !data_req_i) begin
                    addr_d  = pc_i[21:2];
                    en_n_d  = 1'b0;
                    be_n_d  = 4'h0;
                    cnt_d   = 3'd0;
                    state_d = READ;
                end
            end
            READ: begin
                if (cnt_q == WAIT_LAST) begin
                    inst_d  = sram_data_i;
                    en_n_d  = 1'b1;
                    be_n_d  = 4'hF;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                if (!stall_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sram_addr_o  = addr_q;
    assign sram_ce_n_o  = en_n_q;
    assign sram_oe_n_o  = en_n_q;
    assign sram_we_n_o  = 1'b1;
    assign sram_be_n_o  = be_n_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = (state_q == DONE);
    assign stallreq_o   = ce_i && (state_q != DONE);
    assign busy_o       = (state_q == READ);
    assign state_o      = state_q;

endmodule
